conv_sequencer: RTL
===================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameters SHALL be: MAX_DIM, default 5, max input rows/cols; K_MAX, default 3, max kernel rows/cols; ELEM_W, default 8, element width in bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 in_m, in_n  input  3 each  input matrix rows/cols.
REQ-006 k_m, k_n  input  2 each  kernel rows/cols.
REQ-007 matrices_in  input  400  element (r,c) at bits [(r*5+c)*8 +: 8]; only the matrix0 slot (bits 199:0) is used.
REQ-008 kernelMatrix  input  72  element (r,c) at bits [(r*3+c)*8 +: 8].
REQ-009 out_m, out_n  output  3 each  result rows/cols.
REQ-010 matrices_out  output  400  result, same layout as matrices_in.
REQ-011 busy  output  1  high in CHECK, MAC and WRITE.
REQ-012 valid  output  1  one-cycle pulse on completion, success or error.
REQ-013 error  output  1  dimension error; held until the next accepted start.
REQ-014 cycleCount  output  10  number of clocks spent in CHECK, MAC and WRITE for the last job.

Function
REQ-015 The FSM SHALL have states IDLE, CHECK, MAC, WRITE and DONE.
REQ-016 IDLE with start=1: latch all dimension and matrix inputs, clear matrices_out, error and cycleCount, then go to CHECK; start in any other state SHALL be ignored.
REQ-017 CHECK, one cycle, legal job: 1<=k_m<=3, 1<=k_n<=3, k_m<=in_m<=5, k_n<=in_n<=5.
REQ-018 CHECK, legal job: set out_m=in_m-k_m+1 and out_n=in_n-k_n+1, then go to MAC at output (0,0).
REQ-019 CHECK, illegal job: set error=1 and out_m=out_n=0, then go to DONE.
REQ-020 MAC SHALL perform one unsigned 8x8 product per cycle, accumulating into a 20-bit accumulator cleared at the start of each output element.
REQ-021 MAC SHALL scan the kernel row-major, taking k_m*k_n cycles per output element.
REQ-022 WRITE, one cycle: store the accumulator saturated to 255 into slot (i,j).
REQ-023 From WRITE, advance j; when j reaches out_n, wrap j to 0 and increment i.
REQ-024 From WRITE, go to MAC if outputs remain, otherwise go to DONE.
REQ-025 DONE: assert valid for exactly one cycle, then return to IDLE.
REQ-026 Total job latency SHALL be cycleCount = 1 + out_m*out_n*(k_m*k_n+1) for a legal job and 1 for an illegal job.
REQ-027 matrices_out slots outside out_m x out_n SHALL read zero.
REQ-028 matrices_out, out_m, out_n and cycleCount SHALL hold after DONE until the next accepted start.
REQ-029 Changes on latched input ports during a job SHALL NOT affect that job.

Reset
REQ-030 reset low SHALL immediately force IDLE, regardless of state.
REQ-031 reset low SHALL force all outputs to zero, including a job in progress; the aborted job SHALL produce no valid pulse.
REQ-032 After reset release, the first start SHALL be accepted normally.

Structure
REQ-033 A shared package conv_pkg SHALL hold MAX_DIM, K_MAX, ELEM_W, the accumulator width (20), the packed-index arithmetic and the FSM state encoding.
REQ-034 A single sub-module conv_mac SHALL hold the multiply, the 20-bit accumulate, the clear control and the 255 saturation; all sequencing SHALL stay in conv_sequencer.

Verification
REQ-035 Basic job: 4x4 input 1..16 row-major, 2x2 kernel all ones -> out 3x3 = 14 18 22 / 30 34 38 / 46 50 54; cycleCount=46; one valid pulse; error=0.
REQ-036 Saturation: 3x3 input all 255, 3x3 kernel all 255 -> out 1x1 = 255; cycleCount=11.
REQ-037 Illegal job: 2x2 input, 3x3 kernel -> error=1, valid pulse, out_m=out_n=0, cycleCount=1, matrices_out all zero.
REQ-038 Identity-scale job: 5x5 input with (r,c)=r*5+c, 1x1 kernel = 2 -> out 5x5 = 2*(r*5+c); cycleCount=51.
REQ-039 Start while busy: pulse start mid-way through the REQ-035 job -> ignored; results and cycleCount identical to REQ-035.
REQ-040 Reset mid-job: reset low during MAC of a 5x5/3x3 job -> busy=0, outputs zero, no valid pulse; a following REQ-035 job completes correctly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and packed-matrix index helpers for the
// convolution sequencer and its multiply-accumulate datapath.
package conv_pkg;

    localparam int MAX_DIM = 5;
    localparam int K_MAX   = 3;
    localparam int ELEM_W  = 8;
    localparam int ACC_W   = 20;
    localparam int N_MAT   = 2;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Bit offset of element (r,c) in a row-major packed matrix.
    function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                             input int unsigned row_len, input int unsigned ew);
        return (r * row_len + c) * ew;
    endfunction

    function automatic logic dims_legal(input logic [2:0] im, input logic [2:0] in_,
                                        input logic [1:0] km, input logic [1:0] kn,
                                        input int unsigned max_dim, input int unsigned k_max);
        return (km != 2'd0) && (kn != 2'd0)
            && ({30'd0, km} <= k_max) && ({30'd0, kn} <= k_max)
            && ({1'b0, km} <= im) && ({1'b0, kn} <= in_)
            && ({29'd0, im} <= max_dim) && ({29'd0, in_} <= max_dim);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Unsigned multiply-accumulate with per-element clear and saturated readout.
module conv_mac
    import conv_pkg::*;
#(
    parameter int EW = ELEM_W,
    parameter int AW = ACC_W
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [EW-1:0] a_i,
    input  logic [EW-1:0] b_i,
    output logic [EW-1:0] sat_o
);

    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic [2*EW-1:0] prod;

    // clr_i restarts the sum with the current product rather than adding to it.
    always_comb begin
        prod  = a_i * b_i;
        acc_d = acc_q;
        if (en_i) begin
            acc_d = (clr_i ? '0 : acc_q) + AW'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sat_o = (|acc_q[AW-1:EW]) ? '1 : acc_q[EW-1:0];

endmodule

// File: rtl/conv_sequencer.sv
// Valid-mode 2-D convolution sequencer: checks dimensions, walks every output
// element through the kernel one product per cycle, and stores saturated results.
module conv_sequencer #(
    parameter int MAX_DIM = conv_pkg::MAX_DIM,
    parameter int K_MAX   = conv_pkg::K_MAX,
    parameter int ELEM_W  = conv_pkg::ELEM_W
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic [2:0]                                        in_m,
    input  logic [2:0]                                        in_n,
    input  logic [1:0]                                        k_m,
    input  logic [1:0]                                        k_n,
    input  logic [conv_pkg::N_MAT*MAX_DIM*MAX_DIM*ELEM_W-1:0] matrices_in,
    input  logic [K_MAX*K_MAX*ELEM_W-1:0]                     kernelMatrix,
    output logic [2:0]                                        out_m,
    output logic [2:0]                                        out_n,
    output logic [conv_pkg::N_MAT*MAX_DIM*MAX_DIM*ELEM_W-1:0] matrices_out,
    output logic                                              busy,
    output logic                                              valid,
    output logic                                              error,
    output logic [9:0]                                        cycleCount
);
    import conv_pkg::*;

    localparam int SLOT_W = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int MAT_W  = N_MAT * SLOT_W;
    localparam int KER_W  = K_MAX * K_MAX * ELEM_W;
    localparam int IN_IW  = $clog2(SLOT_W);
    localparam int K_IW   = $clog2(KER_W);

    state_t              state_q;
    logic [SLOT_W-1:0]   in_q;
    logic [KER_W-1:0]    ker_q;
    logic [2:0]          in_m_q, in_n_q;
    logic [1:0]          k_m_q, k_n_q;
    logic [2:0]          i_q, j_q;
    logic [1:0]          ki_q, kj_q;
    logic [2:0]          out_m_q, out_n_q;
    logic [SLOT_W-1:0]   mo_q;
    logic                busy_q, valid_q, error_q;
    logic [9:0]          cyc_q;

    logic [2:0]          row_sum, col_sum;
    logic [IN_IW-1:0]    in_lsb, o_lsb;
    logic [K_IW-1:0]     k_lsb;
    logic [ELEM_W-1:0]   mac_a, mac_b, mac_sat;
    logic                mac_en, mac_clr;
    logic                unused_slots;

    assign unused_slots = ^matrices_in[MAT_W-1:SLOT_W];

    assign row_sum = i_q + {1'b0, ki_q};
    assign col_sum = j_q + {1'b0, kj_q};
    assign in_lsb  = IN_IW'(elem_lsb(row_sum, col_sum, MAX_DIM, ELEM_W));
    assign k_lsb   = K_IW'(elem_lsb(ki_q, kj_q, K_MAX, ELEM_W));
    assign o_lsb   = IN_IW'(elem_lsb(i_q, j_q, MAX_DIM, ELEM_W));
    assign mac_a   = in_q[in_lsb +: ELEM_W];
    assign mac_b   = ker_q[k_lsb +: ELEM_W];
    assign mac_en  = (state_q == MAC);
    assign mac_clr = (ki_q == 2'd0) && (kj_q == 2'd0);

    conv_mac #(
        .EW (ELEM_W),
        .AW (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_ni (reset),
        .en_i   (mac_en),
        .clr_i  (mac_clr),
        .a_i    (mac_a),
        .b_i    (mac_b),
        .sat_o  (mac_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            in_q    <= '0;
            ker_q   <= '0;
            in_m_q  <= '0;
            in_n_q  <= '0;
            k_m_q   <= '0;
            k_n_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ki_q    <= '0;
            kj_q    <= '0;
            out_m_q <= '0;
            out_n_q <= '0;
            mo_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            cyc_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        in_q    <= matrices_in[SLOT_W-1:0];
                        ker_q   <= kernelMatrix;
                        in_m_q  <= in_m;
                        in_n_q  <= in_n;
                        k_m_q   <= k_m;
                        k_n_q   <= k_n;
                        mo_q    <= '0;
                        out_m_q <= '0;
                        out_n_q <= '0;
                        error_q <= 1'b0;
                        cyc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    cyc_q <= cyc_q + 10'd1;
                    if (dims_legal(in_m_q, in_n_q, k_m_q, k_n_q, MAX_DIM, K_MAX)) begin
                        out_m_q <= in_m_q - {1'b0, k_m_q} + 3'd1;
                        out_n_q <= in_n_q - {1'b0, k_n_q} + 3'd1;
                        i_q     <= '0;
                        j_q     <= '0;
                        ki_q    <= '0;
                        kj_q    <= '0;
                        state_q <= MAC;
                    end else begin
                        error_q <= 1'b1;
                        out_m_q <= '0;
                        out_n_q <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                MAC: begin
                    cyc_q <= cyc_q + 10'd1;
                    if (kj_q == k_n_q - 2'd1) begin
                        kj_q <= '0;
                        if (ki_q == k_m_q - 2'd1) begin
                            ki_q    <= '0;
                            state_q <= WRITE;
                        end else begin
                            ki_q <= ki_q + 2'd1;
                        end
                    end else begin
                        kj_q <= kj_q + 2'd1;
                    end
                end
                WRITE: begin
                    cyc_q              <= cyc_q + 10'd1;
                    mo_q[o_lsb +: ELEM_W] <= mac_sat;
                    state_q            <= MAC;
                    if (j_q == out_n_q - 3'd1) begin
                        j_q <= '0;
                        if (i_q == out_m_q - 3'd1) begin
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            i_q <= i_q + 3'd1;
                        end
                    end else begin
                        j_q <= j_q + 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_m        = out_m_q;
    assign out_n        = out_n_q;
    assign matrices_out = {{(MAT_W - SLOT_W){1'b0}}, mo_q};
    assign busy         = busy_q;
    assign valid        = valid_q;
    assign error        = error_q;
    assign cycleCount   = cyc_q;

endmodule
